// File: rtl/lru_age_table_if.sv
`default_nettype none
// ============================================================================
// Module      : lru_age_table_if
// Description : Request/response bundle between cache controller and LRU table.
// Revision    : 1.0 - initial release
// ============================================================================
interface lru_age_table_if #(
    parameter int WAYS = 4,
    parameter int SETS = 8
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);

    logic             init_req;
    logic             ready;
    logic             touch_valid;
    logic [SET_W-1:0] touch_set;
    logic [WAY_W-1:0] touch_way;
    logic             lookup_valid;
    logic [SET_W-1:0] lookup_set;
    logic             victim_valid;
    logic [WAY_W-1:0] victim_way;

    modport master (
        output init_req, touch_valid, touch_set, touch_way, lookup_valid, lookup_set,
        input  ready, victim_valid, victim_way
    );

    modport slave (
        input  init_req, touch_valid, touch_set, touch_way, lookup_valid, lookup_set,
        output ready, victim_valid, victim_way
    );
endinterface
`default_nettype wire

// File: rtl/lru_age_table.sv
`default_nettype none
// ============================================================================
// Module      : lru_age_table
// Description : Per-set true-LRU age table with victim lookup and flush sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module lru_age_table #(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    lru_age_table_if.slave     bus
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);
    localparam logic [WAY_W-1:0] C_LRU_AGE  = WAY_W'(WAYS - 1);
    localparam logic [SET_W-1:0] C_LAST_SET = SET_W'(SETS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

    state_t           state_q;
    logic [SET_W-1:0] cnt_q;
    logic             ready_q;
    logic             victim_valid_q;
    logic [WAY_W-1:0] victim_way_q;
    logic [WAY_W-1:0] age_q [SETS][WAYS];

    logic [WAY_W-1:0] touch_old_age;
    logic [WAY_W-1:0] age_touch_d  [WAYS];
    logic [WAY_W-1:0] lookup_row   [WAYS];
    logic [WAY_W-1:0] victim_way_d;

    // Reset pattern makes way 0 the LRU and way WAYS-1 the MRU.
    function automatic logic [WAY_W-1:0] f_reset_age(input int w);
        return WAY_W'(WAYS - 1 - w);
    endfunction

    always_comb begin
        touch_old_age = age_q[bus.touch_set][bus.touch_way];
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == bus.touch_way) begin
                age_touch_d[w] = '0;
            end else if (age_q[bus.touch_set][w] < touch_old_age) begin
                age_touch_d[w] = age_q[bus.touch_set][w] + WAY_W'(1);
            end else begin
                age_touch_d[w] = age_q[bus.touch_set][w];
            end
        end
    end

    // Same-set touch is forwarded so the lookup never names the just-touched way.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            if (bus.touch_valid && (bus.touch_set == bus.lookup_set)) begin
                lookup_row[w] = age_touch_d[w];
            end else begin
                lookup_row[w] = age_q[bus.lookup_set][w];
            end
        end
        victim_way_d = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (lookup_row[w] == C_LRU_AGE) begin
                victim_way_d = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= f_reset_age(w);
                end
            end
            state_q        <= IDLE;
            cnt_q          <= '0;
            ready_q        <= 1'b1;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.init_req) begin
                        state_q        <= INIT;
                        cnt_q          <= '0;
                        ready_q        <= 1'b0;
                        victim_valid_q <= 1'b0;
                    end else begin
                        if (bus.touch_valid) begin
                            for (int w = 0; w < WAYS; w++) begin
                                age_q[bus.touch_set][w] <= age_touch_d[w];
                            end
                        end
                        victim_valid_q <= bus.lookup_valid;
                        if (bus.lookup_valid) begin
                            victim_way_q <= victim_way_d;
                        end
                    end
                end
                INIT: begin
                    for (int w = 0; w < WAYS; w++) begin
                        age_q[cnt_q][w] <= f_reset_age(w);
                    end
                    cnt_q          <= cnt_q + SET_W'(1);
                    victim_valid_q <= 1'b0;
                    if (cnt_q == C_LAST_SET) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready        = ready_q;
    assign bus.victim_valid = victim_valid_q;
    assign bus.victim_way   = victim_way_q;
endmodule
`default_nettype wire
